// File: rtl/gbuff_checker.sv
// gbuff_checker: after a TPU run, streams the output global buffer and the
// golden memory side by side, compares every word lane by lane, reports each
// mismatching word and keeps a saturating count of mismatching lanes.
module gbuff_checker #(
  parameter int DATA_W  = 32,
  parameter int LANE_W  = 8,
  parameter int ADDR_W  = 16,
  parameter int MAX_CYC = 100000,
  parameter int ERR_W   = 16,
  localparam int LANES  = DATA_W / LANE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_words,
  input  logic              lane_swap,
  input  logic              tpu_done,
  output logic              out_rd_en,
  output logic [ADDR_W-1:0] out_addr,
  input  logic [DATA_W-1:0] out_rdata,
  output logic              gold_rd_en,
  output logic [ADDR_W-1:0] gold_addr,
  input  logic [DATA_W-1:0] gold_rdata,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr,
  output logic [LANES-1:0]  err_mask,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout
);

  localparam int WD_W  = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int PC_W  = $clog2(LANES + 1);
  localparam int SUM_W = ERR_W + PC_W;

  typedef enum logic [2:0] {IDLE, WAIT, READ, DRAIN, FINISH} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  num_q;
  logic               swap_q;
  logic [ADDR_W:0]    rd_cnt;
  logic [ADDR_W-1:0]  rd_addr;
  logic               rd_en;
  logic [WD_W-1:0]    wd;
  logic               drain_cnt;

  logic               cmp_v;
  logic [ADDR_W-1:0]  cmp_addr;
  logic [DATA_W-1:0]  gold_sw;
  logic [LANES-1:0]   lane_mis;
  logic [PC_W-1:0]    err_pop;
  logic [SUM_W-1:0]   cnt_sum;

  assign out_rd_en  = rd_en;
  assign gold_rd_en = rd_en;
  assign out_addr   = rd_addr;
  assign gold_addr  = rd_addr;
  assign busy       = (state != IDLE);

  // Reorder golden lanes (optionally reversed) and flag each differing output lane
  always_comb begin
    gold_sw  = '0;
    lane_mis = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      gold_sw[k*LANE_W +: LANE_W] = swap_q ? gold_rdata[(LANES-1-k)*LANE_W +: LANE_W]
                                           : gold_rdata[k*LANE_W +: LANE_W];
      lane_mis[k] = (out_rdata[k*LANE_W +: LANE_W] != gold_sw[k*LANE_W +: LANE_W]);
    end
  end

  // Popcount of the reported mask and the widened sum used for saturation
  always_comb begin
    err_pop = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      err_pop = err_pop + PC_W'(err_mask[k]);
    end
    cnt_sum = SUM_W'(err_cnt) + SUM_W'(err_pop);
  end

  // Compare stage: data returns one cycle after the read, result registered one cycle later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp_v     <= 1'b0;
      cmp_addr  <= '0;
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_mask  <= '0;
    end else begin
      cmp_v     <= rd_en;
      cmp_addr  <= rd_addr;
      err_valid <= cmp_v && (|lane_mis);
      if (cmp_v && (|lane_mis)) begin
        err_addr <= cmp_addr;
        err_mask <= lane_mis;
      end
    end
  end

  // Control FSM with registered read strobes, status flags and error counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      num_q     <= '0;
      swap_q    <= 1'b0;
      rd_cnt    <= '0;
      rd_addr   <= '0;
      rd_en     <= 1'b0;
      wd        <= '0;
      drain_cnt <= 1'b0;
      err_cnt   <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (err_valid) begin
        if (cnt_sum[SUM_W-1:ERR_W] != '0) err_cnt <= '1;
        else                               err_cnt <= cnt_sum[ERR_W-1:0];
      end
      case (state)
        IDLE: begin
          if (start) begin
            state   <= WAIT;
            num_q   <= num_words;
            swap_q  <= lane_swap;
            err_cnt <= '0;
            pass    <= 1'b0;
            timeout <= 1'b0;
            wd      <= '0;
          end
        end
        WAIT: begin
          if (tpu_done || (wd == WD_W'(MAX_CYC - 1))) begin
            if (!tpu_done) timeout <= 1'b1;
            if (num_q == '0) begin
              state     <= DRAIN;
              drain_cnt <= 1'b0;
            end else begin
              state   <= READ;
              rd_en   <= 1'b1;
              rd_addr <= '0;
              rd_cnt  <= (ADDR_W+1)'(1);
            end
          end else begin
            wd <= wd + 1'b1;
          end
        end
        READ: begin
          // rd_cnt counts issued reads and is one bit wider than the address,
          // so a full-range word count stops cleanly instead of wrapping
          if (rd_cnt == {1'b0, num_q}) begin
            rd_en     <= 1'b0;
            state     <= DRAIN;
            drain_cnt <= 1'b0;
          end else begin
            rd_addr <= rd_cnt[ADDR_W-1:0];
            rd_cnt  <= rd_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            state <= FINISH;
            done  <= 1'b1;
            // the last word's error pulse is in flight this cycle and not yet in err_cnt
            pass  <= !timeout && (err_cnt == '0) && !err_valid;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gbuff_checker.sv
// Scoreboard bench for gbuff_checker: directed checks with hand-computed
// expectations queued by the stimulus and retired by an independent monitor.
module tb_gbuff_checker;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int EW = 4;
  localparam int LN = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] num_words;
  logic          lane_swap;
  logic          tpu_done;
  logic          out_rd_en, gold_rd_en;
  logic [AW-1:0] out_addr, gold_addr;
  logic [DW-1:0] out_rdata, gold_rdata;
  logic          err_valid;
  logic [AW-1:0] err_addr;
  logic [LN-1:0] err_mask;
  logic [EW-1:0] err_cnt;
  logic          busy, done, pass, timeout;

  gbuff_checker #(
    .DATA_W (DW),
    .LANE_W (8),
    .ADDR_W (AW),
    .MAX_CYC(50),
    .ERR_W  (EW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_words (num_words),
    .lane_swap (lane_swap),
    .tpu_done  (tpu_done),
    .out_rd_en (out_rd_en),
    .out_addr  (out_addr),
    .out_rdata (out_rdata),
    .gold_rd_en(gold_rd_en),
    .gold_addr (gold_addr),
    .gold_rdata(gold_rdata),
    .err_valid (err_valid),
    .err_addr  (err_addr),
    .err_mask  (err_mask),
    .err_cnt   (err_cnt),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [LN-1:0] mask;
  } err_t;

  typedef struct {
    logic          pass;
    logic          to;
    logic [EW-1:0] cnt;
  } done_t;

  err_t          err_q[$];
  done_t         done_q[$];
  logic [AW-1:0] rd_q[$];

  logic [DW-1:0] out_mem [256];
  logic [DW-1:0] gold_mem[256];
  int            rd_cyc  [256];
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Memory models: registered read, data valid one cycle after the strobe
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (out_rd_en)  out_rdata  <= out_mem[out_addr];
    if (gold_rd_en) gold_rdata <= gold_mem[gold_addr];
  end

  // Monitor: retire expected reads, error reports and completions
  always @(negedge clk) begin
    if (rst) begin
      if (out_rd_en || gold_rd_en) begin
        chk("rd_en_pair", {63'd0, gold_rd_en}, {63'd0, out_rd_en});
        chk("addr_pair", 64'(gold_addr), 64'(out_addr));
        rd_cyc[out_addr] = cyc;
        chk("rd_expected", 64'(rd_q.size() != 0), 64'd1);
        if (rd_q.size() != 0) chk("rd_addr", 64'(out_addr), 64'(rd_q.pop_front()));
      end
      if (err_valid) begin
        chk("err_expected", 64'(err_q.size() != 0), 64'd1);
        if (err_q.size() != 0) begin
          err_t e;
          e = err_q.pop_front();
          chk("err_addr", 64'(err_addr), 64'(e.addr));
          chk("err_mask", 64'(err_mask), 64'(e.mask));
          chk("err_latency", 64'(cyc - rd_cyc[err_addr]), 64'd2);
        end
      end
      if (done) begin
        chk("done_expected", 64'(done_q.size() != 0), 64'd1);
        if (done_q.size() != 0) begin
          done_t d;
          d = done_q.pop_front();
          chk("done_pass", 64'(pass), 64'(d.pass));
          chk("done_timeout", 64'(timeout), 64'(d.to));
          chk("done_err_cnt", 64'(err_cnt), 64'(d.cnt));
        end
      end
    end
  end

  task automatic push_reads(input int n);
    for (int i = 0; i < n; i++) rd_q.push_back(AW'(i));
  endtask

  task automatic push_err(input int a, input logic [LN-1:0] m);
    err_t e;
    e.addr = AW'(a);
    e.mask = m;
    err_q.push_back(e);
  endtask

  task automatic check_zero(input string p);
    chk({p, "_rd"}, 64'({out_rd_en, gold_rd_en}), 64'd0);
    chk({p, "_addr"}, 64'({out_addr, gold_addr}), 64'd0);
    chk({p, "_err"}, 64'({err_valid, err_addr, err_mask}), 64'd0);
    chk({p, "_cnt"}, 64'(err_cnt), 64'd0);
    chk({p, "_status"}, 64'({busy, done, pass, timeout}), 64'd0);
  endtask

  task automatic end_check(input string p);
    chk({p, "_rd_left"}, 64'(rd_q.size()), 64'd0);
    chk({p, "_err_left"}, 64'(err_q.size()), 64'd0);
    chk({p, "_done_left"}, 64'(done_q.size()), 64'd0);
  endtask

  // dly: negedges after start before tpu_done rises (-1 = never)
  // exp_first: expected negedge index of the first read (-1 = not checked)
  task automatic run(input string p, input int nw, input logic sw, input int dly,
                     input int exp_first, input logic ep, input logic et,
                     input logic [EW-1:0] ec);
    done_t d;
    int    n;
    int    first;
    logic  got;
    d.pass = ep;
    d.to   = et;
    d.cnt  = ec;
    done_q.push_back(d);
    num_words = AW'(nw);
    lane_swap = sw;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({p, "_busy"}, 64'(busy), 64'd1);
    n = 0;
    first = -1;
    got = 1'b0;
    while (!got && n < 400) begin
      if (dly >= 0 && n == dly) tpu_done = 1'b1;
      if (first < 0 && out_rd_en) first = n;
      if (done) got = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    tpu_done = 1'b0;
    chk({p, "_done_seen"}, 64'(got), 64'd1);
    if (exp_first >= 0) chk({p, "_first_rd"}, 64'(first), 64'(exp_first));
    @(negedge clk);
    chk({p, "_done_pulse"}, 64'({done, busy}), 64'd0);
    chk({p, "_hold"}, 64'({pass, timeout, err_cnt}), 64'({ep, et, ec}));
    end_check(p);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b0;
    start = 1'b0;
    lane_swap = 1'b0;
    tpu_done = 1'b0;
    num_words = '0;
    for (int i = 0; i < 256; i++) begin
      out_mem[i]  = '0;
      gold_mem[i] = '0;
      rd_cyc[i]   = 0;
    end
    repeat (3) @(negedge clk);
    check_zero("reset");
    @(negedge clk);
    #1 rst = 1'b1;

    // matching data, tpu_done ten cycles after start
    for (int i = 0; i < 8; i++) begin
      gold_mem[i] = 32'h10203040 + 32'h01010101 * 32'(i);
      out_mem[i]  = gold_mem[i];
    end
    push_reads(4);
    run("match", 4, 1'b0, 10, 11, 1'b1, 1'b0, 4'd0);

    // word 2, lanes 0 and 3 corrupted
    out_mem[2] = gold_mem[2] ^ 32'hFF0000FF;
    push_reads(4);
    push_err(2, 4'b1001);
    run("lane03", 4, 1'b0, 3, 4, 1'b0, 1'b0, 4'd2);

    // lane reversal, tpu_done already high after start
    gold_mem[0] = 32'h11223344;
    out_mem[0]  = 32'h44332211;
    push_reads(1);
    run("swap1", 1, 1'b1, 0, 1, 1'b1, 1'b0, 4'd0);
    push_reads(1);
    push_err(0, 4'b1111);
    run("swap0", 1, 1'b0, 0, 1, 1'b0, 1'b0, 4'd4);

    // watchdog expiry with matching data
    gold_mem[0] = 32'hCAFEF00D;
    out_mem[0]  = 32'hCAFEF00D;
    gold_mem[1] = 32'h0BADBEEF;
    out_mem[1]  = 32'h0BADBEEF;
    push_reads(2);
    run("timeout", 2, 1'b0, -1, 50, 1'b0, 1'b1, 4'd0);

    // five fully mismatching words saturate the 4-bit counter
    for (int i = 0; i < 5; i++) begin
      gold_mem[i] = 32'h5A5A5A5A + 32'(i);
      out_mem[i]  = ~gold_mem[i];
      push_err(i, 4'b1111);
    end
    push_reads(5);
    run("saturate", 5, 1'b0, 2, 3, 1'b0, 1'b0, 4'd15);

    // zero words: no reads, counter cleared by the new start
    run("zero", 0, 1'b0, 0, -1, 1'b1, 1'b0, 4'd0);

    // start during READ is ignored, reset mid-READ aborts
    for (int i = 0; i < 8; i++) begin
      gold_mem[i] = 32'h77000000 + 32'(i);
      out_mem[i]  = gold_mem[i];
    end
    num_words = AW'(8);
    lane_swap = 1'b0;
    tpu_done = 1'b1;
    push_reads(8);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!out_rd_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_rd_started", 64'(out_rd_en), 64'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ignored_start_busy", 64'(busy), 64'd1);
    chk("ignored_start_rd", 64'(out_rd_en), 64'd1);
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check_zero("abort");
    @(negedge clk);
    #1 rst = 1'b1;
    tpu_done = 1'b0;
    rd_q.delete();
    repeat (4) begin
      @(negedge clk);
      chk("after_abort_idle", 64'({busy, done, out_rd_en}), 64'd0);
    end
    push_reads(3);
    run("restart", 3, 1'b0, 1, 2, 1'b1, 1'b0, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
